// File: rtl/pipe_ctrl_unit_if.sv
// Control bus between pipe_ctrl_unit and the RV32I datapath.
// master: the control unit (consumes ID instruction and EX flags, drives controls).
// slave:  the datapath side.
interface pipe_ctrl_unit_if #(
  parameter int RF_ADDR_W = 5,
  parameter int ALU_OP_W  = 4
);
  logic [31:0]          inst_id;
  logic                 zero_ex;
  logic                 sign_ex;
  logic [2:0]           imm_sel;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic [ALU_OP_W-1:0]  ex_alu_op;
  logic                 ex_a_sel;
  logic                 ex_b_sel;
  logic [1:0]           npc_op;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic                 mem_dram_we;
  logic                 wb_rf_we;
  logic [1:0]           wb_wd_sel;
  logic [RF_ADDR_W-1:0] wb_rd;

  modport master (
    input  inst_id, zero_ex, sign_ex,
    output imm_sel, pc_en, ifid_en, ifid_flush, ex_alu_op, ex_a_sel, ex_b_sel,
           npc_op, fwd_a_sel, fwd_b_sel, mem_dram_we, wb_rf_we, wb_wd_sel, wb_rd
  );

  modport slave (
    output inst_id, zero_ex, sign_ex,
    input  imm_sel, pc_en, ifid_en, ifid_flush, ex_alu_op, ex_a_sel, ex_b_sel,
           npc_op, fwd_a_sel, fwd_b_sel, mem_dram_we, wb_rf_we, wb_wd_sel, wb_rd
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Five-stage RV32I pipeline control unit: ID decode, ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, EX branch resolution, flush and
// operand forwarding selects.
// Optional M-extension multi-cycle support: define PIPE_CTRL_MULDIV_EN.
module pipe_ctrl_unit #(
  parameter int RF_ADDR_W  = 5,
  parameter int ALU_OP_W   = 4,
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  pipe_ctrl_unit_if.master bus
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // ALU encodings
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'b1000;

  // Immediate selects
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;

  localparam logic [RF_ADDR_W-1:0] RF_ZERO = '0;

  // Legal EX occupancy for a muldiv op is at least two cycles.
  if (MULDIV_LAT < 2) begin : g_bad_lat
    $error("pipe_ctrl_unit: MULDIV_LAT must be >= 2");
  end

  // ID/EX bundle; unused source fields are zeroed at decode so that
  // hazard and forwarding compares never see spurious matches.
  typedef struct packed {
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 a_sel;
    logic                 b_sel;
    logic                 dram_we;
    logic                 rf_we;
    logic [1:0]           wd_sel;
    logic                 is_load;
    logic                 is_branch;
    logic                 is_jal;
    logic                 is_jalr;
    logic [2:0]           funct3;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
  } idex_t;

  typedef struct packed {
    logic                 dram_we;
    logic                 rf_we;
    logic [1:0]           wd_sel;
    logic                 is_load;
    logic [RF_ADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                 rf_we;
    logic [1:0]           wd_sel;
    logic [RF_ADDR_W-1:0] rd;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;

  // ALU op for R / I-ALU by funct3; alt selects sub/sra. slt/sltu map to sub.
  function automatic logic [ALU_OP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SUB;
      3'b011:  alu_fn = ALU_SUB;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  endfunction

  // Forwarding select for one EX source: EX/MEM (non-load) wins over MEM/WB.
  function automatic logic [1:0] fwd_fn(input logic [RF_ADDR_W-1:0] rs,
                                        input exmem_t em, input memwb_t mw);
    if ((rs != RF_ZERO) && em.rf_we && !em.is_load && (em.rd == rs)) begin
      fwd_fn = 2'b01;
    end else if ((rs != RF_ZERO) && mw.rf_we && (mw.rd == rs)) begin
      fwd_fn = 2'b10;
    end else begin
      fwd_fn = 2'b00;
    end
  endfunction

  logic [6:0]           opcode_s;
  logic [2:0]           funct3_s;
  logic [6:0]           funct7_s;
  logic [RF_ADDR_W-1:0] rd_s;
  logic [RF_ADDR_W-1:0] rs1_s;
  logic [RF_ADDR_W-1:0] rs2_s;

  idex_t  id_s;
  logic [2:0] imm_sel_s;
  idex_t  idex_r, idex_nxt_s;
  exmem_t exmem_r, exmem_nxt_s;
  memwb_t memwb_r;

  logic [1:0] npc_op_s;
  logic       taken_s;
  logic       load_use_s;
  logic       busy_s;
  logic       id_load_s;
  logic       pc_en_s;
  logic       ifid_en_s;
  logic       ifid_flush_s;

  assign opcode_s = bus.inst_id[6:0];
  assign rd_s     = bus.inst_id[7 +: RF_ADDR_W];
  assign funct3_s = bus.inst_id[14:12];
  assign rs1_s    = bus.inst_id[15 +: RF_ADDR_W];
  assign rs2_s    = bus.inst_id[20 +: RF_ADDR_W];
  assign funct7_s = bus.inst_id[31:25];

`ifdef PIPE_CTRL_MULDIV_EN
  logic id_muldiv_s;
`endif

  // ID decode of the current instruction into the control bundle.
  always_comb begin
    id_s      = IDEX_BUBBLE;
    imm_sel_s = IMM_I;
`ifdef PIPE_CTRL_MULDIV_EN
    id_muldiv_s = 1'b0;
`endif
    case (opcode_s)
      OP_R: begin
        id_s.rd     = rd_s;
        id_s.rs1    = rs1_s;
        id_s.rs2    = rs2_s;
        id_s.rf_we  = 1'b1;
        id_s.alu_op = alu_fn(funct3_s, funct7_s == 7'b0100000);
`ifdef PIPE_CTRL_MULDIV_EN
        // M-extension ops occupy the 1xxx space with funct3 in the low bits.
        if (funct7_s == 7'b0000001) begin
          id_s.alu_op = {1'b1, funct3_s};
          id_muldiv_s = 1'b1;
        end else begin
          id_muldiv_s = 1'b0;
        end
`endif
      end
      OP_IMM: begin
        id_s.rd     = rd_s;
        id_s.rs1    = rs1_s;
        id_s.rf_we  = 1'b1;
        id_s.b_sel  = 1'b1;
        id_s.alu_op = alu_fn(funct3_s, (funct3_s == 3'b101) && (funct7_s == 7'b0100000));
        imm_sel_s   = ((funct3_s == 3'b001) || (funct3_s == 3'b101)) ? IMM_SHAMT : IMM_I;
      end
      OP_LOAD: begin
        id_s.rd      = rd_s;
        id_s.rs1     = rs1_s;
        id_s.rf_we   = 1'b1;
        id_s.b_sel   = 1'b1;
        id_s.alu_op  = ALU_ADD;
        id_s.is_load = 1'b1;
        id_s.wd_sel  = 2'b01;
        imm_sel_s    = IMM_I;
      end
      OP_STORE: begin
        id_s.rs1     = rs1_s;
        id_s.rs2     = rs2_s;
        id_s.b_sel   = 1'b1;
        id_s.alu_op  = ALU_ADD;
        id_s.dram_we = 1'b1;
        imm_sel_s    = IMM_S;
      end
      OP_BRANCH: begin
        id_s.rs1       = rs1_s;
        id_s.rs2       = rs2_s;
        id_s.alu_op    = ALU_SUB;
        id_s.is_branch = 1'b1;
        id_s.funct3    = funct3_s;
        imm_sel_s      = IMM_B;
      end
      OP_LUI: begin
        id_s.rd     = rd_s;
        id_s.rf_we  = 1'b1;
        id_s.b_sel  = 1'b1;
        id_s.alu_op = ALU_LUI;
        imm_sel_s   = IMM_U;
      end
      OP_JAL: begin
        id_s.rd     = rd_s;
        id_s.rf_we  = 1'b1;
        id_s.a_sel  = 1'b1;
        id_s.b_sel  = 1'b1;
        id_s.alu_op = ALU_ADD;
        id_s.wd_sel = 2'b11;
        id_s.is_jal = 1'b1;
        imm_sel_s   = IMM_J;
      end
      OP_JALR: begin
        id_s.rd      = rd_s;
        id_s.rs1     = rs1_s;
        id_s.rf_we   = 1'b1;
        id_s.b_sel   = 1'b1;
        id_s.alu_op  = ALU_ADD;
        id_s.wd_sel  = 2'b11;
        id_s.is_jalr = 1'b1;
        imm_sel_s    = IMM_I;
      end
      default: begin
        id_s      = IDEX_BUBBLE;
        imm_sel_s = IMM_I;
      end
    endcase
    // x0 is never written.
    id_s.rf_we = id_s.rf_we & (id_s.rd != RF_ZERO);
  end

  // Next-PC resolution for the instruction in EX.
  always_comb begin
    npc_op_s = 2'b00;
    if (idex_r.is_jal) begin
      npc_op_s = 2'b10;
    end else if (idex_r.is_jalr) begin
      npc_op_s = 2'b11;
    end else if (idex_r.is_branch) begin
      case (idex_r.funct3)
        3'b000:  npc_op_s = bus.zero_ex  ? 2'b01 : 2'b00;
        3'b001:  npc_op_s = !bus.zero_ex ? 2'b01 : 2'b00;
        3'b100:  npc_op_s = bus.sign_ex  ? 2'b01 : 2'b00;
        3'b101:  npc_op_s = !bus.sign_ex ? 2'b01 : 2'b00;
        default: npc_op_s = 2'b00;
      endcase
    end else begin
      npc_op_s = 2'b00;
    end
  end

  assign taken_s    = (npc_op_s != 2'b00);
  assign load_use_s = idex_r.is_load && (idex_r.rd != RF_ZERO) &&
                      ((id_s.rs1 == idex_r.rd) || (id_s.rs2 == idex_r.rd));

`ifdef PIPE_CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_LAT);
  logic [CNT_W-1:0] cnt_r;

  assign busy_s = (cnt_r != '0);

  // Muldiv occupancy counter: loads on entry to EX, counts down to release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (id_load_s && id_muldiv_s) begin
      cnt_r <= CNT_W'(MULDIV_LAT - 1);
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end
`else
  assign busy_s = 1'b0;
`endif

  // Stall/flush arbitration: taken branch/jump > muldiv busy > load-use.
  always_comb begin
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_nxt_s   = id_s;
    id_load_s    = 1'b1;
    if (taken_s) begin
      ifid_flush_s = 1'b1;
      idex_nxt_s   = IDEX_BUBBLE;
      id_load_s    = 1'b0;
    end else if (busy_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_nxt_s = idex_r;
      id_load_s  = 1'b0;
    end else if (load_use_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_nxt_s = IDEX_BUBBLE;
      id_load_s  = 1'b0;
    end else begin
      idex_nxt_s = id_s;
      id_load_s  = 1'b1;
    end
  end

  // EX/MEM receives bubbles while a muldiv op still occupies EX.
  always_comb begin
    exmem_nxt_s = EXMEM_BUBBLE;
    if (busy_s) begin
      exmem_nxt_s = EXMEM_BUBBLE;
    end else begin
      exmem_nxt_s.dram_we = idex_r.dram_we;
      exmem_nxt_s.rf_we   = idex_r.rf_we;
      exmem_nxt_s.wd_sel  = idex_r.wd_sel;
      exmem_nxt_s.is_load = idex_r.is_load;
      exmem_nxt_s.rd      = idex_r.rd;
    end
  end

  // Pipeline control registers, cleared to bubbles on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_r  <= IDEX_BUBBLE;
      exmem_r <= EXMEM_BUBBLE;
      memwb_r <= '0;
    end else begin
      idex_r         <= idex_nxt_s;
      exmem_r        <= exmem_nxt_s;
      memwb_r.rf_we  <= exmem_r.rf_we;
      memwb_r.wd_sel <= exmem_r.wd_sel;
      memwb_r.rd     <= exmem_r.rd;
    end
  end

  assign bus.imm_sel     = imm_sel_s;
  assign bus.pc_en       = pc_en_s;
  assign bus.ifid_en     = ifid_en_s;
  assign bus.ifid_flush  = ifid_flush_s;
  assign bus.npc_op      = npc_op_s;
  assign bus.ex_alu_op   = idex_r.alu_op;
  assign bus.ex_a_sel    = idex_r.a_sel;
  assign bus.ex_b_sel    = idex_r.b_sel;
  assign bus.fwd_a_sel   = fwd_fn(idex_r.rs1, exmem_r, memwb_r);
  assign bus.fwd_b_sel   = fwd_fn(idex_r.rs2, exmem_r, memwb_r);
  assign bus.mem_dram_we = exmem_r.dram_we;
  assign bus.wb_rf_we    = memwb_r.rf_we;
  assign bus.wb_wd_sel   = memwb_r.wd_sel;
  assign bus.wb_rd       = memwb_r.rd;

endmodule
